// File: rtl/i2c_mmc_release_arbiter.sv
// rtl/i2c_mmc_release_arbiter.sv - Arbitrates two local I2C masters for a bus shared with the MMC
//
// Two local masters (FMC, DDR3) share an I2C bus that the MMC owns by default.
// Before either master gets a grant, the arbiter asks the MMC to release the
// bus and waits for its acknowledge. Grants between the two masters are
// round-robin, and the bus is handed straight from one master to the other
// without giving it back to the MMC.
//
// Optional feature macro: I2C_ARB_ACK_TIMEOUT_EN
//   When defined, a wait in REQ of ACK_TIMEOUT cycles without ack sets the
//   sticky o_AckTimeout_p flag and gives the bus back. When undefined, the
//   arbiter waits for ack indefinitely and o_AckTimeout_p is tied to 0.
//
// Ports:
//   i_SysClk_p            system clock, all logic in this domain
//   i_nSysRst_p           asynchronous active-low reset
//   iv2_I2cReq_p          level requests from the two local masters
//   ov2_I2cGrant_p        one-hot grant (never 2'b11)
//   o_MmcI2cReleaseReq_p  release request to the MMC
//   i_MmcI2cReleaseAck_p  asynchronous release acknowledge from the MMC
//   o_AckTimeout_p        sticky acknowledge-timeout flag
//   i_TimeoutClr_p        single-cycle clear for o_AckTimeout_p

module i2c_mmc_release_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 32'd1_000_000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       i_SysClk_p,
    input  logic       i_nSysRst_p,
    input  logic [1:0] iv2_I2cReq_p,
    output logic [1:0] ov2_I2cGrant_p,
    output logic       o_MmcI2cReleaseReq_p,
    input  logic       i_MmcI2cReleaseAck_p,
    output logic       o_AckTimeout_p,
    input  logic       i_TimeoutClr_p
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_HANDOFF = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Out-of-range parameters elaborate this empty marker block so they are
    // easy to spot in the elaborated hierarchy.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ACK_TIMEOUT == 0) begin : g_illegal_params
    end

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [1:0]             r_grant;
    logic                   r_rel_req;
    logic                   r_rr_ptr;   // index of the requester favoured next
    logic                   r_owner;    // index of the requester granted last

    logic w_ack;
    logic w_win;
    logic w_to_hit;

    assign w_ack = r_ack_sync[SYNC_STAGES-1];
    // Favoured requester wins if it is asking, otherwise the other one does.
    assign w_win = iv2_I2cReq_p[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

`ifdef I2C_ARB_ACK_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout;

    assign w_to_hit       = (r_state == ST_REQ) && !w_ack &&
                            (r_to_cnt == ACK_TIMEOUT - 32'd1);
    assign o_AckTimeout_p = r_timeout;
`else
    logic w_unused_clr;

    assign w_to_hit       = 1'b0;
    assign w_unused_clr   = i_TimeoutClr_p;
    assign o_AckTimeout_p = 1'b0;
`endif

    always_ff @(posedge i_SysClk_p or negedge i_nSysRst_p) begin
        if (!i_nSysRst_p) begin
            r_state    <= ST_IDLE;
            r_ack_sync <= '0;
            r_grant    <= 2'b00;
            r_rel_req  <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_owner    <= 1'b0;
`ifdef I2C_ARB_ACK_TIMEOUT_EN
            r_to_cnt   <= 32'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_MmcI2cReleaseAck_p};

            case (r_state)
                ST_IDLE: begin
                    if (|iv2_I2cReq_p) begin
                        r_rel_req <= 1'b1;
                        r_state   <= ST_REQ;
`ifdef I2C_ARB_ACK_TIMEOUT_EN
                        r_to_cnt  <= 32'd0;
`endif
                    end
                end

                ST_REQ: begin
                    if (w_ack) begin
                        r_state <= ST_GRANT;
                        // A request dropped before ack still completes the
                        // REQ; GRANT then sees no grant and unwinds.
                        if (|iv2_I2cReq_p) begin
                            r_grant  <= {w_win, ~w_win};
                            r_owner  <= w_win;
                            r_rr_ptr <= ~w_win;
                        end
                    end else if (w_to_hit) begin
                        r_rel_req <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end
`ifdef I2C_ARB_ACK_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end

                ST_GRANT: begin
                    if (r_grant == 2'b00 || !iv2_I2cReq_p[r_owner]) begin
                        r_grant <= 2'b00;
                        r_state <= ST_HANDOFF;
                    end
                end

                ST_HANDOFF: begin
                    // Hand the bus to the other master without giving it
                    // back to the MMC.
                    if (iv2_I2cReq_p[~r_owner]) begin
                        r_grant  <= {~r_owner, r_owner};
                        r_owner  <= ~r_owner;
                        r_rr_ptr <= r_owner;
                        r_state  <= ST_GRANT;
                    end else begin
                        r_rel_req <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!w_ack) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_grant   <= 2'b00;
                    r_rel_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase

`ifdef I2C_ARB_ACK_TIMEOUT_EN
            // A timeout in the same cycle as a clear wins.
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end else if (i_TimeoutClr_p) begin
                r_timeout <= 1'b0;
            end
`endif
        end
    end

    assign ov2_I2cGrant_p       = r_grant;
    assign o_MmcI2cReleaseReq_p = r_rel_req;

endmodule

// File: tb/tb_i2c_mmc_release_arbiter.sv
// tb/tb_i2c_mmc_release_arbiter.sv - Directed self-checking bench for i2c_mmc_release_arbiter

module tb_i2c_mmc_release_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] grant;
    logic       rel_req;
    logic       ack;
    logic       to_flag;
    logic       to_clr;

    int n_pass  = 0;
    int n_total = 0;
    int n_both  = 0;

    i2c_mmc_release_arbiter #(
        .ACK_TIMEOUT (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_SysClk_p           (clk),
        .i_nSysRst_p          (rst_n),
        .iv2_I2cReq_p         (req),
        .ov2_I2cGrant_p       (grant),
        .o_MmcI2cReleaseReq_p (rel_req),
        .i_MmcI2cReleaseAck_p (ack),
        .o_AckTimeout_p       (to_flag),
        .i_TimeoutClr_p       (to_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (grant === 2'b11) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 2'b00;
        ack    = 1'b0;
        to_clr = 1'b0;
        #2;
        chk("reset_grant", {30'd0, grant}, 32'd0);
        chk("reset_relreq", {31'd0, rel_req}, 32'd0);
        chk("reset_timeout", {31'd0, to_flag}, 32'd0);
        step(2);
        rst_n = 1'b1;

        // Single request, ack rises 5 cycles after the release request.
        req = 2'b01;
        step(1);
        chk("t1_relreq_up", {31'd0, rel_req}, 32'd1);
        chk("t1_no_grant_yet", {30'd0, grant}, 32'd0);
        step(4);
        ack = 1'b1;
        step(2);
        chk("t1_grant_latency_early", {30'd0, grant}, 32'd0);
        step(1);
        chk("t1_grant_01", {30'd0, grant}, 32'd1);
        step(3);
        chk("t1_grant_held", {30'd0, grant}, 32'd1);
        req = 2'b00;
        step(1);
        chk("t1_handoff_grant", {30'd0, grant}, 32'd0);
        chk("t1_handoff_relreq", {31'd0, rel_req}, 32'd1);
        step(1);
        chk("t1_release_relreq", {31'd0, rel_req}, 32'd0);

        // Ack still high in RELEASE: a new request must wait for ack to fall.
        req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t6_release_hold_relreq", {31'd0, rel_req}, 32'd0);
            chk("t6_release_hold_grant", {30'd0, grant}, 32'd0);
        end
        ack = 1'b0;
        step(3);
        chk("t6_still_idle", {31'd0, rel_req}, 32'd0);
        step(1);
        chk("t6_req_restart", {31'd0, rel_req}, 32'd1);
        ack = 1'b1;
        step(3);
        chk("t6_grant_10", {30'd0, grant}, 32'd2);
        req = 2'b00;
        step(2);
        ack = 1'b0;
        step(4);

        // Both requesting from IDLE after reset: req0 wins, then handoff.
        do_reset();
        req = 2'b11;
        step(1);
        chk("t2_relreq_up", {31'd0, rel_req}, 32'd1);
        ack = 1'b1;
        step(3);
        chk("t2_grant_01", {30'd0, grant}, 32'd1);
        req = 2'b10;
        step(1);
        chk("t2_handoff_grant", {30'd0, grant}, 32'd0);
        chk("t2_handoff_relreq", {31'd0, rel_req}, 32'd1);
        step(1);
        chk("t2_grant_10", {30'd0, grant}, 32'd2);
        chk("t2_relreq_kept", {31'd0, rel_req}, 32'd1);

        // req0 comes back while req1 is still held, then req1 leaves.
        req = 2'b11;
        step(2);
        chk("t3_grant_10_held", {30'd0, grant}, 32'd2);
        req = 2'b01;
        step(1);
        chk("t3_handoff_grant", {30'd0, grant}, 32'd0);
        step(1);
        chk("t3_grant_01", {30'd0, grant}, 32'd1);
        chk("t3_relreq_kept", {31'd0, rel_req}, 32'd1);

        // Reset while granted drops outputs with no clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", {30'd0, grant}, 32'd0);
        chk("t5_async_relreq", {31'd0, rel_req}, 32'd0);
        ack = 1'b0;
        req = 2'b10;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t5_restart_relreq", {31'd0, rel_req}, 32'd1);
        chk("t5_restart_nogrant", {30'd0, grant}, 32'd0);
        ack = 1'b1;
        step(3);
        chk("t5_grant_10", {30'd0, grant}, 32'd2);
        req = 2'b00;
        step(2);
        ack = 1'b0;
        step(4);

        // Ack never arrives.
        do_reset();
        req = 2'b01;
        step(1);
        chk("t4_relreq_up", {31'd0, rel_req}, 32'd1);
`ifdef I2C_ARB_ACK_TIMEOUT_EN
        step(15);
        chk("t4_no_timeout_yet", {31'd0, to_flag}, 32'd0);
        chk("t4_relreq_before", {31'd0, rel_req}, 32'd1);
        step(1);
        chk("t4_timeout_set", {31'd0, to_flag}, 32'd1);
        chk("t4_relreq_dropped", {31'd0, rel_req}, 32'd0);
        chk("t4_no_grant", {30'd0, grant}, 32'd0);
        req = 2'b00;
        step(3);
        chk("t4_timeout_sticky", {31'd0, to_flag}, 32'd1);
        to_clr = 1'b1;
        step(1);
        to_clr = 1'b0;
        chk("t4_timeout_cleared", {31'd0, to_flag}, 32'd0);
`else
        step(30);
        chk("t4_still_waiting", {31'd0, rel_req}, 32'd1);
        chk("t4_no_grant", {30'd0, grant}, 32'd0);
        chk("t4_flag_tied", {31'd0, to_flag}, 32'd0);
        ack = 1'b1;
        step(3);
        chk("t4_late_grant", {30'd0, grant}, 32'd1);
        req = 2'b00;
        step(2);
        ack = 1'b0;
        step(4);
`endif

        chk("never_grant_11", n_both, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
